// File: rtl/naive_divider_seq.sv
// naive_divider_seq: restoring divider, one quotient bit per enabled cycle; NAIVEDIV_STICKY_EN adds a sticky output
module naive_divider_seq #(
  parameter int LEN = 4
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             regenable,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic [2*LEN-1:0] s_axis_tdata_a,
  input  logic [LEN-1:0]   s_axis_tdata_b,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic [2*LEN-1:0] quotient,
  output logic [LEN-1:0]   remainder,
  output logic             div_by_zero
`ifdef NAIVEDIV_STICKY_EN
  ,
  output logic             sticky
`endif
);
  localparam int CW = $clog2(2*LEN+1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, nstate;
  logic [LEN-1:0] pr, bd, df;
  logic [2*LEN-1:0] dq, dqn;
  logic [CW-1:0] cnt;
  logic [LEN:0] sh, sub;
  logic ge, acc, fin, ack;
  // sh/sub carry one extra bit so the trial-subtract sign is visible
  always_comb begin
    sh  = {pr, dq[2*LEN-1]};
    sub = sh - {1'b0, bd};
    ge  = !sub[LEN];
    df  = ge ? sub[LEN-1:0] : sh[LEN-1:0];
    dqn = {dq[2*LEN-2:0], ge};
    acc = s_axis_tvalid && state == IDLE;
    fin = state == BUSY && cnt == CW'(1);
    ack = m_axis_tready && state == DONE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) state <= IDLE;
    else if (regenable) state <= nstate;
  always_comb begin
    nstate = acc ? (s_axis_tdata_b == '0 ? DONE : BUSY) : fin ? DONE : ack ? IDLE : state;
  end
  always_comb begin
    s_axis_tready = state == IDLE;
    m_axis_tvalid = state == DONE;
  end
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      pr          <= '0;
      dq          <= '0;
      bd          <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef NAIVEDIV_STICKY_EN
      sticky      <= 1'b0;
`endif
    end else if (regenable) begin
      if (acc) begin
        pr  <= '0;
        dq  <= s_axis_tdata_a;
        bd  <= s_axis_tdata_b;
        cnt <= CW'(2*LEN);
        if (s_axis_tdata_b == '0) begin
          quotient    <= '1;
          remainder   <= s_axis_tdata_a[LEN-1:0];
          div_by_zero <= 1'b1;
`ifdef NAIVEDIV_STICKY_EN
          sticky      <= |s_axis_tdata_a[LEN-1:0];
`endif
        end
      end else if (state == BUSY) begin
        pr  <= df;
        dq  <= dqn;
        cnt <= cnt - 1'b1;
        if (fin) begin
          quotient  <= dqn;
          remainder <= df;
`ifdef NAIVEDIV_STICKY_EN
          sticky    <= |df;
`endif
        end
      end else if (ack) div_by_zero <= 1'b0;
    end
endmodule

// File: tb/tb_naive_divider_seq.sv
// tb_naive_divider_seq: directed vectors for naive_divider_seq at LEN=4
module tb_naive_divider_seq;
  localparam int LEN = 4;
  logic aclk = 1'b0, aresetn = 1'b0, regenable = 1'b1;
  logic s_axis_tvalid = 1'b0, s_axis_tready, m_axis_tvalid, m_axis_tready = 1'b1;
  logic [2*LEN-1:0] s_axis_tdata_a = '0, quotient;
  logic [LEN-1:0] s_axis_tdata_b = '0, remainder;
  logic div_by_zero;
`ifdef NAIVEDIV_STICKY_EN
  logic sticky;
`endif
  int checks = 0, errors = 0, lat;
  logic seen;
  naive_divider_seq #(.LEN(LEN)) dut (
    .aclk(aclk), .aresetn(aresetn), .regenable(regenable),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata_a(s_axis_tdata_a), .s_axis_tdata_b(s_axis_tdata_b),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
`ifdef NAIVEDIV_STICKY_EN
    , .sticky(sticky)
`endif
  );
  always #5 aclk = ~aclk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [7:0] a, input logic [3:0] b, input int st, input int sl, output int l);
    int n;
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata_a = a;
    s_axis_tdata_b = b;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tdata_a = 8'h5A;
    s_axis_tdata_b = 4'h3;
    n = 1;
    while (!m_axis_tvalid && n < 100) begin
      if (n == st) regenable = 1'b0;
      if (n == st + sl) regenable = 1'b1;
      @(negedge aclk);
      n++;
    end
    regenable = 1'b1;
    l = m_axis_tvalid ? n : -1;
  endtask
  task automatic expect_res(input string t, input logic [7:0] q, input logic [3:0] r, input logic z);
    check({t, "_q"}, 32'(quotient), 32'(q));
    check({t, "_r"}, 32'(remainder), 32'(r));
    check({t, "_dbz"}, 32'(div_by_zero), 32'(z));
`ifdef NAIVEDIV_STICKY_EN
    check({t, "_sticky"}, 32'(sticky), 32'(r != 4'd0));
`endif
  endtask
  task automatic expect_idle(input string t);
    @(negedge aclk);
    check({t, "_mvalid_after"}, 32'(m_axis_tvalid), 0);
    check({t, "_sready_after"}, 32'(s_axis_tready), 1);
  endtask
  initial begin
    #12;
    check("rst_sready", 32'(s_axis_tready), 1);
    check("rst_mvalid", 32'(m_axis_tvalid), 0);
    check("rst_q", 32'(quotient), 0);
    check("rst_r", 32'(remainder), 0);
    check("rst_dbz", 32'(div_by_zero), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    run(8'd200, 4'd7, 0, 0, lat);
    check("d200_7_lat", 32'(lat), 9);
    expect_res("d200_7", 8'd28, 4'd4, 1'b0);
    expect_idle("d200_7");
    run(8'd255, 4'd1, 0, 0, lat);
    check("d255_1_lat", 32'(lat), 9);
    expect_res("d255_1", 8'd255, 4'd0, 1'b0);
    expect_idle("d255_1");
    m_axis_tready = 1'b0;
    run(8'd15, 4'd15, 0, 0, lat);
    check("d15_15_lat", 32'(lat), 9);
    expect_res("d15_15", 8'd1, 4'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("bp_mvalid", 32'(m_axis_tvalid), 1);
      check("bp_sready", 32'(s_axis_tready), 0);
      check("bp_q", 32'(quotient), 1);
      check("bp_r", 32'(remainder), 0);
    end
    m_axis_tready = 1'b1;
    expect_idle("bp");
    run(8'hAB, 4'd0, 0, 0, lat);
    check("dz_lat", 32'(lat), 1);
    expect_res("dz", 8'hFF, 4'hB, 1'b1);
    expect_idle("dz");
    check("dz_clear", 32'(div_by_zero), 0);
    run(8'd100, 4'd9, 3, 3, lat);
    check("stall_lat", 32'(lat), 12);
    expect_res("stall", 8'd11, 4'd1, 1'b0);
    expect_idle("stall");
    @(negedge aclk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata_a = 8'd123;
    s_axis_tdata_b = 4'd5;
    @(negedge aclk);
    s_axis_tvalid = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    #1;
    check("abort_mvalid", 32'(m_axis_tvalid), 0);
    check("abort_sready", 32'(s_axis_tready), 1);
    @(negedge aclk);
    aresetn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge aclk);
      seen = seen | m_axis_tvalid;
    end
    check("abort_nostale", 32'(seen), 0);
    run(8'd50, 4'd5, 0, 0, lat);
    check("d50_5_lat", 32'(lat), 9);
    expect_res("d50_5", 8'd10, 4'd0, 1'b0);
    expect_idle("d50_5");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/naive_divider_seq.md
Name: naive_divider_seq

Overview:
- Sequential restoring divider for mantissa arithmetic. It is the inverse path to the combinational LEN x LEN mantissa multiplier.
- Takes a 2*LEN-bit dividend (product-width) and a LEN-bit divisor. Returns a 2*LEN-bit quotient and a LEN-bit remainder.
- Produces one quotient bit per enabled cycle, behind AXI-Stream-style valid/ready handshakes on input and output.
- Sits in the tensor-core datapath wherever mantissa division or reciprocal scaling is needed.

Parameters:
- LEN, 4, mantissa operand width. Dividend and quotient are 2*LEN bits; divisor and remainder are LEN bits. Legal range 2..16.

Ports:
- aclk  input  1  clock, all state on rising edge
- aresetn  input  1  asynchronous active-low reset
- regenable  input  1  register enable; when 0 all internal state and outputs hold (stall)
- s_axis_tvalid  input  1  operand pair valid
- s_axis_tready  output  1  block can accept operands
- s_axis_tdata_a  input  2*LEN  dividend
- s_axis_tdata_b  input  LEN  divisor
- m_axis_tvalid  output  1  result valid
- m_axis_tready  input  1  downstream accepts result
- quotient  output  2*LEN  floor(a/b)
- remainder  output  LEN  a mod b
- div_by_zero  output  1  set with result when b==0

Behaviour:
- Reset: aresetn low asynchronously forces state IDLE and clears all of the following to 0:
  - m_axis_tvalid, quotient, remainder, div_by_zero
  - internal shift and count registers
- s_axis_tready is 1 in IDLE. Deassertion of aresetn is synchronous to aclk.
- FSM states: IDLE, BUSY, DONE. All transitions and register updates happen only on edges where regenable==1.
- IDLE:
  - s_axis_tready=1. On s_axis_tvalid&&s_axis_tready, latch a and b.
  - If b!=0: clear the partial remainder (LEN+1 bits), load count=2*LEN, go to BUSY.
  - If b==0: quotient=all ones, remainder=a[LEN-1:0], div_by_zero=1, go directly to DONE.
- BUSY, one iteration per enabled cycle:
  - Shift {partial remainder, dividend} left by one.
  - Trial subtract b from the partial remainder. If the result is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
  - Decrement count. When count reaches 1 on this edge, go to DONE.
- DONE: m_axis_tvalid=1. Outputs are stable and held until m_axis_tvalid&&m_axis_tready, then go to IDLE (m_axis_tvalid=0, div_by_zero=0).
- s_axis_tready=0 in BUSY and DONE. There is no input/output overlap; throughput is one result per 2*LEN+2 enabled cycles minimum.
- Latency, nonzero divisor: m_axis_tvalid rises 2*LEN+1 enabled edges after the acceptance edge (including the acceptance edge). Latency for a zero divisor is 1 edge.
- regenable=0 for N cycles stretches latency by exactly N. A handshake occurring while regenable==0 is not a transfer; valid/ready outputs hold their values.
- Quotient is exact for all inputs. A full 2*LEN-bit quotient is needed because a/b can reach (2^(2*LEN))-1 when b==1.
- Remainder is always < b. It fits LEN bits; the internal partial remainder is LEN+1 bits to hold the trial-subtract carry.
- Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded and nothing is emitted after reset.
- Inputs are ignored outside IDLE. s_axis_tdata_* may change freely while BUSY.

Optional Feature:
- Macro NAIVEDIV_STICKY_EN.
- When defined: an extra output port sticky (1 bit) is added. It equals (remainder!=0), is registered with the result, is valid when m_axis_tvalid=1, resets to 0, and is 1 on divide-by-zero if a[LEN-1:0]!=0. It is used for FP rounding.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- LEN=4, a=200, b=7, m_axis_tready=1 -> quotient=28, remainder=4, div_by_zero=0; m_axis_tvalid 9 edges after acceptance; sticky=1 if enabled.
- a=255, b=1 -> quotient=255, remainder=0; sticky=0. Also a=15, b=15 -> quotient=1, remainder=0.
- a=0xAB, b=0 -> quotient=0xFF, remainder=0xB, div_by_zero=1; m_axis_tvalid 1 edge after acceptance.
- Backpressure: hold m_axis_tready=0 for 5 cycles after valid -> outputs stable, s_axis_tready stays 0. Release -> one transfer, then s_axis_tready=1 on the next cycle.
- regenable low for 3 cycles mid-BUSY with a=100, b=9 -> quotient=11, remainder=1, latency 9+3 edges.
- aresetn pulsed low mid-BUSY -> m_axis_tvalid=0, s_axis_tready=1 immediately; no stale result emitted. A following a=50, b=5 gives quotient=10, remainder=0.
